// File: rtl/decode_ctrl_pipe.sv
// Decode/control stage for the pipelined 8-bit processor: splits the instruction word,
// registers EX controls, carries writeback controls to DM, forwards and stalls on load-use.
module decode_ctrl_pipe #(
  parameter int unsigned OP_W     = 5,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned IMM_W    = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned INS_W    = 24,
  parameter bit          SIGN_EXT = 1'b0,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  ins,
  output logic [DATA_W-1:0] imm,
  output logic [OP_W-1:0]   op_dec,
  output logic [1:0]        mux_sel_A,
  output logic [1:0]        mux_sel_B,
  output logic              imm_sel,
  output logic              mem_en_ex,
  output logic              mem_rw_ex,
  output logic [RA_W-1:0]   RW_dm,
  output logic              wr_en_dm,
  output logic              mem_mux_sel_dm,
  output logic              stall
);

  localparam int unsigned RdMsb  = INS_W - OP_W - 1;
  localparam int unsigned Rs1Msb = RdMsb - RA_W;
  localparam int unsigned Rs2Msb = Rs1Msb - RA_W;

  localparam logic [1:0] SelRegFile = 2'b00;
  localparam logic [1:0] SelFwd1    = 2'b01;
  localparam logic [1:0] SelFwd2    = 2'b10;

  typedef enum logic [2:0] {
    ClsNop,
    ClsLoad,
    ClsStore,
    ClsAluImm,
    ClsAluReg
  } cls_e;

  // Instruction fields
  logic [OP_W-1:0]   op_f;
  logic [RA_W-1:0]   rd_f;
  logic [RA_W-1:0]   rs1_f;
  logic [RA_W-1:0]   rs2_f;
  logic [IMM_W-1:0]  imm_f;
  logic [DATA_W-1:0] imm_ext;

  assign op_f  = ins[INS_W-1 -: OP_W];
  assign rd_f  = ins[RdMsb -: RA_W];
  assign rs1_f = ins[Rs1Msb -: RA_W];
  assign rs2_f = ins[Rs2Msb -: RA_W];
  assign imm_f = ins[Rs2Msb -: IMM_W];

  // Low instruction bits below the widest trailing field carry no information
  logic unused_ins;
  assign unused_ins = ^ins;

  // Decode
  cls_e            cls;
  logic            use_a;
  logic            use_b;
  logic            writes;
  logic [RA_W-1:0] src_b;

  always_comb begin
    cls = ClsAluReg;
    if (&op_f) begin
      cls = ClsNop;
    end else if (op_f[OP_W-1 -: 2] == 2'b10) begin
      cls = op_f[0] ? ClsStore : ClsLoad;
    end else if (op_f[OP_W-1 -: 2] == 2'b01) begin
      cls = ClsAluImm;
    end
  end

  assign use_a  = (cls != ClsNop);
  assign use_b  = (cls == ClsStore) || (cls == ClsAluReg);
  assign writes = (cls == ClsLoad) || (cls == ClsAluImm) || (cls == ClsAluReg);
  // Stores read their data operand through the rd field
  assign src_b  = (cls == ClsStore) ? rd_f : rs2_f;

  always_comb begin
    imm_ext = {DATA_W{SIGN_EXT & imm_f[IMM_W-1]}};
    imm_ext[IMM_W-1:0] = imm_f;
  end

  // Pipeline state
  cls_e            cls_ex_q;
  cls_e            cls_dm_q;
  logic [RA_W-1:0] rd_ex_q;
  logic [RA_W-1:0] rd_dm_q;
  logic            wr_ex_q;
  logic            wr_dm_q;

  logic [DATA_W-1:0] imm_q;
  logic [OP_W-1:0]   op_q;
  logic [1:0]        sel_a_q;
  logic [1:0]        sel_b_q;
  logic              imm_sel_q;
  logic              mem_en_q;
  logic              mem_rw_q;

  function automatic logic reg_hit(input logic [RA_W-1:0] src, input logic [RA_W-1:0] dst,
                                   input logic wr);
    return wr && (src == dst) && !(ZERO_REG && (src == '0));
  endfunction

  logic       hit_a1;
  logic       hit_a2;
  logic       hit_b1;
  logic       hit_b2;
  logic [1:0] sel_a_d;
  logic [1:0] sel_b_d;

  assign hit_a1 = use_a && reg_hit(rs1_f, rd_ex_q, wr_ex_q);
  assign hit_a2 = use_a && reg_hit(rs1_f, rd_dm_q, wr_dm_q);
  assign hit_b1 = use_b && reg_hit(src_b, rd_ex_q, wr_ex_q);
  assign hit_b2 = use_b && reg_hit(src_b, rd_dm_q, wr_dm_q);

  always_comb begin
    sel_a_d = SelRegFile;
    sel_b_d = SelRegFile;
    if (hit_a1) begin
      sel_a_d = SelFwd1;
    end else if (hit_a2) begin
      sel_a_d = SelFwd2;
    end
    if (hit_b1) begin
      sel_b_d = SelFwd1;
    end else if (hit_b2) begin
      sel_b_d = SelFwd2;
    end
  end

  // A load result is not available to the very next instruction
  assign stall = (cls_ex_q == ClsLoad) && (hit_a1 || hit_b1);

  // ID/EX register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imm_q     <= '0;
      op_q      <= '0;
      sel_a_q   <= SelRegFile;
      sel_b_q   <= SelRegFile;
      imm_sel_q <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_rw_q  <= 1'b0;
      cls_ex_q  <= ClsNop;
      rd_ex_q   <= '0;
      wr_ex_q   <= 1'b0;
    end else if (stall) begin
      imm_q     <= '0;
      op_q      <= '1;
      sel_a_q   <= SelRegFile;
      sel_b_q   <= SelRegFile;
      imm_sel_q <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_rw_q  <= 1'b0;
      cls_ex_q  <= ClsNop;
      rd_ex_q   <= '0;
      wr_ex_q   <= 1'b0;
    end else begin
      imm_q     <= imm_ext;
      op_q      <= op_f;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      imm_sel_q <= (cls == ClsLoad) || (cls == ClsStore) || (cls == ClsAluImm);
      mem_en_q  <= (cls == ClsLoad) || (cls == ClsStore);
      mem_rw_q  <= (cls == ClsStore);
      cls_ex_q  <= cls;
      rd_ex_q   <= rd_f;
      wr_ex_q   <= writes;
    end
  end

  // EX/DM register advances even while ID/EX takes a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cls_dm_q <= ClsNop;
      rd_dm_q  <= '0;
      wr_dm_q  <= 1'b0;
    end else begin
      cls_dm_q <= cls_ex_q;
      rd_dm_q  <= rd_ex_q;
      wr_dm_q  <= wr_ex_q;
    end
  end

  assign imm            = imm_q;
  assign op_dec         = op_q;
  assign mux_sel_A      = sel_a_q;
  assign mux_sel_B      = sel_b_q;
  assign imm_sel        = imm_sel_q;
  assign mem_en_ex      = mem_en_q;
  assign mem_rw_ex      = mem_rw_q;
  assign RW_dm          = rd_dm_q;
  assign wr_en_dm       = wr_dm_q;
  assign mem_mux_sel_dm = (cls_dm_q == ClsLoad);

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench for decode_ctrl_pipe: a default instance and a 16-bit sign-extending
// instance without the zero register, both fed the same instruction stream.
module tb_decode_ctrl_pipe;

  logic        clk;
  logic        reset;
  logic [23:0] ins;

  logic [7:0]  imm0;
  logic [4:0]  op0;
  logic [1:0]  sa0, sb0;
  logic        isel0, men0, mrw0, wr0, mms0, stall0;
  logic [4:0]  rw0;

  logic [15:0] imm1;
  logic [4:0]  op1;
  logic [1:0]  sa1, sb1;
  logic        isel1, men1, mrw1, wr1, mms1, stall1;
  logic [4:0]  rw1;

  decode_ctrl_pipe u_dut (
    .clk           (clk),
    .reset         (reset),
    .ins           (ins),
    .imm           (imm0),
    .op_dec        (op0),
    .mux_sel_A     (sa0),
    .mux_sel_B     (sb0),
    .imm_sel       (isel0),
    .mem_en_ex     (men0),
    .mem_rw_ex     (mrw0),
    .RW_dm         (rw0),
    .wr_en_dm      (wr0),
    .mem_mux_sel_dm(mms0),
    .stall         (stall0)
  );

  decode_ctrl_pipe #(
    .DATA_W  (16),
    .SIGN_EXT(1'b1),
    .ZERO_REG(1'b0)
  ) u_dut_alt (
    .clk           (clk),
    .reset         (reset),
    .ins           (ins),
    .imm           (imm1),
    .op_dec        (op1),
    .mux_sel_A     (sa1),
    .mux_sel_B     (sb1),
    .imm_sel       (isel1),
    .mem_en_ex     (men1),
    .mem_rw_ex     (mrw1),
    .RW_dm         (rw1),
    .wr_en_dm      (wr1),
    .mem_mux_sel_dm(mms1),
    .stall         (stall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic [15:0] imm;
    logic [4:0]  op;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic        isel;
    logic        men;
    logic        mrw;
  } ex_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       mms;
  } dm_t;

  ex_t ex_q0[$];
  ex_t ex_q1[$];
  dm_t dm_q0[$];
  dm_t dm_q1[$];

  // Model of the two in-flight instructions, per configuration
  logic       h1_wr[2], h1_ld[2], h2_wr[2];
  logic [4:0] h1_rd[2], h2_rd[2];
  logic       zr[2];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fsel(input int c, input logic used, input logic [4:0] r);
    if (!used || (zr[c] && r == 5'd0)) return 2'b00;
    if (h1_wr[c] && h1_rd[c] == r) return 2'b01;
    if (h2_wr[c] && h2_rd[c] == r) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model(input int c, input logic [23:0] v, output ex_t e, output dm_t d);
    logic [4:0] op, rd, rs1, rs2, rb;
    logic [7:0] immf;
    logic is_nop, is_ld, is_st, is_ai, ua, ub, wr, st, ha, hb;
    op = v[23:19]; rd = v[18:14]; rs1 = v[13:9]; rs2 = v[8:4]; immf = v[8:1];
    is_nop = (op == 5'h1f);
    is_ld  = !is_nop && op[4:3] == 2'b10 && !op[0];
    is_st  = !is_nop && op[4:3] == 2'b10 && op[0];
    is_ai  = !is_nop && op[4:3] == 2'b01;
    ua = !is_nop;
    ub = !is_nop && !is_ld && !is_ai;
    rb = is_st ? rd : rs2;
    wr = !is_nop && !is_st;
    ha = ua && !(zr[c] && rs1 == 5'd0) && h1_wr[c] && h1_rd[c] == rs1;
    hb = ub && !(zr[c] && rb == 5'd0) && h1_wr[c] && h1_rd[c] == rb;
    st = h1_ld[c] && (ha || hb);
    if (st) begin
      e = '{stall: 1'b1, imm: 16'h0, op: 5'h1f, sa: 2'b00, sb: 2'b00,
            isel: 1'b0, men: 1'b0, mrw: 1'b0};
      d = '{rd: 5'd0, wr: 1'b0, mms: 1'b0};
    end else begin
      e.stall = 1'b0;
      e.imm   = (c == 0) ? {8'h00, immf} : {{8{immf[7]}}, immf};
      e.op    = op;
      e.sa    = fsel(c, ua, rs1);
      e.sb    = fsel(c, ub, rb);
      e.isel  = is_ld || is_st || is_ai;
      e.men   = is_ld || is_st;
      e.mrw   = is_st;
      d = '{rd: rd, wr: wr, mms: is_ld};
    end
    h2_wr[c] = h1_wr[c];
    h2_rd[c] = h1_rd[c];
    h1_wr[c] = d.wr;
    h1_rd[c] = d.rd;
    h1_ld[c] = d.mms;
  endtask

  task automatic check_ex(input string p, input ex_t e, input logic [15:0] g_imm,
                          input logic [4:0] g_op, input logic [1:0] g_sa, input logic [1:0] g_sb,
                          input logic g_isel, input logic g_men, input logic g_mrw);
    check({p, "imm"}, 32'(g_imm), 32'(e.imm));
    check({p, "op_dec"}, 32'(g_op), 32'(e.op));
    check({p, "mux_sel_A"}, 32'(g_sa), 32'(e.sa));
    check({p, "mux_sel_B"}, 32'(g_sb), 32'(e.sb));
    check({p, "imm_sel"}, 32'(g_isel), 32'(e.isel));
    check({p, "mem_en_ex"}, 32'(g_men), 32'(e.men));
    check({p, "mem_rw_ex"}, 32'(g_mrw), 32'(e.mrw));
  endtask

  task automatic check_dm(input string p, input dm_t d, input logic [4:0] g_rd, input logic g_wr,
                          input logic g_mms);
    check({p, "wr_en_dm"}, 32'(g_wr), 32'(d.wr));
    check({p, "mem_mux_sel_dm"}, 32'(g_mms), 32'(d.mms));
    if (d.wr) check({p, "RW_dm"}, 32'(g_rd), 32'(d.rd));
  endtask

  // One clock: apply ins, score stall, then score the registered outputs after the edge
  task automatic step_once(input logic [23:0] v, output logic stalled);
    ex_t e0, e1, p0, p1;
    dm_t d0, d1, q0, q1;
    ins = v;
    #1;
    model(0, v, e0, d0);
    model(1, v, e1, d1);
    check("c0_stall", 32'(stall0), 32'(e0.stall));
    check("c1_stall", 32'(stall1), 32'(e1.stall));
    ex_q0.push_back(e0); dm_q0.push_back(d0);
    ex_q1.push_back(e1); dm_q1.push_back(d1);
    stalled = e0.stall;
    @(posedge clk);
    #1;
    p0 = ex_q0.pop_front(); q0 = dm_q0.pop_front();
    p1 = ex_q1.pop_front(); q1 = dm_q1.pop_front();
    check_ex("c0_", p0, {8'h00, imm0}, op0, sa0, sb0, isel0, men0, mrw0);
    check_ex("c1_", p1, imm1, op1, sa1, sb1, isel1, men1, mrw1);
    check_dm("c0_", q0, rw0, wr0, mms0);
    check_dm("c1_", q1, rw1, wr1, mms1);
  endtask

  // Issue one instruction, holding it for an extra cycle if the model says it stalls
  task automatic issue(input logic [23:0] v);
    logic st;
    step_once(v, st);
    if (st) step_once(v, st);
  endtask

  task automatic check_reset_state(input string p);
    check({p, "imm0"}, 32'(imm0), 32'h0);
    check({p, "op0"}, 32'(op0), 32'h0);
    check({p, "sel0"}, {28'h0, sa0, sb0}, 32'h0);
    check({p, "ctl0"}, {27'h0, isel0, men0, mrw0, wr0, mms0}, 32'h0);
    check({p, "rw0"}, 32'(rw0), 32'h0);
    check({p, "stall0"}, 32'(stall0), 32'h0);
    check({p, "imm1"}, 32'(imm1), 32'h0);
    check({p, "ctl1"}, {20'h0, op1, sa1, sb1, isel1, men1, mrw1}, 32'h0);
    check({p, "dm1"}, {25'h0, rw1, wr1, mms1}, 32'h0);
    check({p, "stall1"}, 32'(stall1), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_state("rst_");
    ins = 24'hFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_hold_");
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      h1_wr[c] = 1'b0; h1_ld[c] = 1'b0; h2_wr[c] = 1'b0;
      h1_rd[c] = 5'd0; h2_rd[c] = 5'd0;
    end
    ex_q0.delete(); ex_q1.delete(); dm_q0.delete(); dm_q1.delete();
    dm_q0.push_back('0);
    dm_q1.push_back('0);
  endtask

  function automatic logic [23:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ops[6];
    zr[0] = 1'b1;
    zr[1] = 1'b0;
    ins   = 24'h0;
    reset = 1'b0;
    #2;
    do_reset();

    // ALU-reg rd1 <- r2, r3 then drain
    issue(24'b00000_00001_00010_00011_0000);
    issue(24'hFFFFFF);
    // Load-use: stall, bubble, then forward from 2-ahead
    issue(24'b10100_00100_00001_00000_0000);
    issue(mk(5'b00000, 5'd7, 5'd4, 5'd2));
    issue(24'hFFFFFF);
    issue(24'hFFFFFF);
    // 1-ahead forwarding on both operands, then 2-ahead via a NOP
    issue(mk(5'b00000, 5'd5, 5'd1, 5'd2));
    issue(24'b00100_00110_00101_00101_0000);
    issue(mk(5'b00000, 5'd5, 5'd1, 5'd2));
    issue(24'hFFFFFF);
    issue(24'b00100_00110_00101_00101_0000);
    // ALU-imm, positive and negative immediates
    issue(24'b01101_00110_00001_00000101_0);
    issue(24'b01101_00110_00001_10000101_0);
    // r0 writer then reader
    issue(mk(5'b00000, 5'd0, 5'd1, 5'd2));
    issue(mk(5'b00000, 5'd3, 5'd0, 5'd0));
    // Store data operand forwarded from a 1-ahead ALU writer
    issue(mk(5'b00000, 5'd9, 5'd1, 5'd2));
    issue(mk(5'b10101, 5'd9, 5'd3, 5'd0));
    issue(24'hFFFFFF);
    issue(24'hFFFFFF);
    // Back-to-back loads to r4, then a use
    issue(mk(5'b10100, 5'd4, 5'd1, 5'd0));
    issue(mk(5'b10100, 5'd4, 5'd2, 5'd0));
    issue(mk(5'b00000, 5'd8, 5'd4, 5'd4));
    issue(24'hFFFFFF);

    // Reset arriving while a stall is pending
    issue(mk(5'b10100, 5'd4, 5'd1, 5'd0));
    ins = mk(5'b00000, 5'd7, 5'd4, 5'd2);
    #1;
    check("midstall_pre", 32'(stall0), 32'h1);
    do_reset();
    issue(mk(5'b00000, 5'd7, 5'd4, 5'd2));
    issue(24'hFFFFFF);

    // Mixed random traffic over a small register window
    ops[0] = 5'b00000; ops[1] = 5'b10100; ops[2] = 5'b10101;
    ops[3] = 5'b01101; ops[4] = 5'b11111; ops[5] = 5'b11010;
    for (int i = 0; i < 60; i++) begin
      logic [23:0] v;
      v = 24'($urandom);
      v[23:19] = ops[$urandom_range(0, 5)];
      v[18:17] = 2'b00; v[13:12] = 2'b00; v[8:7] = 2'b00;
      issue(v);
    end
    issue(24'hFFFFFF);
    issue(24'hFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Parametrised decode/control unit for the pipelined 8-bit processor, sitting between the instruction fetch register and the execute stage. Each cycle it splits the instruction word, registers the EX-stage controls, and carries destination and writeback controls to the DM stage. Beyond the fixed-width decoder it:
- generalises field and data widths;
- selects forwarding sources from two in-flight instructions;
- detects load-use hazards and stalls with a bubble;
- supports an optional hard-wired zero register.

## Interface
Parameters:
- OP_W, 5, opcode field width
- RA_W, 5, register-address field width
- IMM_W, 8, immediate field width
- DATA_W, 8, datapath width; imm is extended to this width
- INS_W, 24, instruction width; must be ≥ OP_W+2*RA_W+max(RA_W,IMM_W)
- SIGN_EXT, 0, 1 = sign-extend imm, 0 = zero-extend
- ZERO_REG, 1, 1 = register 0 is never a forwarding or hazard match

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- ins  in  INS_W  instruction from fetch register
- imm  out  DATA_W  extended immediate, EX stage
- op_dec  out  OP_W  opcode, EX stage
- mux_sel_A  out  2  operand A source: 00 regfile, 01 fwd from 1-ahead, 10 fwd from 2-ahead
- mux_sel_B  out  2  operand B source, same encoding
- imm_sel  out  1  operand B = imm, EX stage
- mem_en_ex  out  1  data memory enable, EX stage
- mem_rw_ex  out  1  1 = write (store), 0 = read, EX stage
- RW_dm  out  RA_W  destination register, DM stage
- wr_en_dm  out  1  register writeback enable, DM stage
- mem_mux_sel_dm  out  1  1 = writeback from memory, 0 = from ALU, DM stage
- stall  out  1  combinational; when 1, fetch must hold ins for the next edge

## Operation
Fields are MSB-aligned, in this order:
- op = ins[INS_W-1 -: OP_W]
- rd = next RA_W bits
- rs1 = next RA_W bits
- rs2 = next RA_W bits
- immediate = IMM_W bits directly below rs1 (overlaps rs2)

Instruction class, from op top two bits (t):
- op all-ones: NOP. No sources, no write.
- t=10, op[0]=0: LOAD. Source A = rs1; imm_sel=1, mem_en=1, mem_rw=0; writes rd; mem_mux_sel=1.
- t=10, op[0]=1: STORE. Source A = rs1, source B = rd; imm_sel=1, mem_en=1, mem_rw=1; no write.
- t=01: ALU-imm. Source A = rs1; imm_sel=1; writes rd.
- Otherwise: ALU-reg. Sources rs1 and rs2; writes rd.

Pipeline state:
- ID/EX register holds class, rd and the write flag for the instruction 1-ahead.
- EX/DM register holds the same for the instruction 2-ahead.

Forwarding:
- For each source, sel = 01 if the 1-ahead instruction writes that register.
- Else sel = 10 if the 2-ahead instruction writes it.
- Else sel = 00.
- 1-ahead has priority over 2-ahead.
- Register 0 is never matched when ZERO_REG=1.
- A source a class does not use always gives sel 00.

Load-use hazard:
- stall = 1 when the 1-ahead instruction is a LOAD and a used source of the current ins matches its rd (subject to ZERO_REG).
- On a stall edge, ID/EX loads a bubble: all EX controls 0, op_dec all-ones, no write. EX/DM advances normally.
- Next cycle the load is 2-ahead, so stall drops and the held instruction issues with sel 10.

## Timing
- Reset (asynchronous, while high):
  - imm, op_dec, mux_sel_A/B, imm_sel, mem_en_ex, mem_rw_ex, RW_dm, wr_en_dm, mem_mux_sel_dm are all 0.
  - Pipeline write flags are cleared, so stall=0.
  - First edge after release decodes ins normally.
- EX controls (imm, op_dec, mux_sel_*, imm_sel, mem_*_ex) are valid 1 cycle after ins is sampled.
- DM controls (RW_dm, wr_en_dm, mem_mux_sel_dm) are valid 2 cycles after ins is sampled.
- stall is combinational from ins and ID/EX; it has no registered latency.
- Reset asserted mid-stall: the stall clears immediately and the bubble is discarded.
- Back-to-back loads to the same rd, then a use: stall for one cycle only, then forward from the newest load.

## Test plan
- Reset high → all outputs 0, stall 0. Release, ins=00000_00001_00010_00011_0000 (ALU-reg rd1, rs1=2, rs2=3) → next edge: op_dec=0, sel A/B=00, imm_sel=0. One edge later: RW_dm=1, wr_en_dm=1.
- LOAD ins=10100_00100_00001_00000_0000, then ALU-reg using rs1=4 → stall=1 for one cycle, ID/EX bubble (mem_en_ex=0). Then mux_sel_A=10; load reaches DM with mem_mux_sel_dm=1, RW_dm=4.
- ALU-reg writing r5, then ins=00100_00110_00101_00101_0000 → mux_sel_A=01, mux_sel_B=01, no stall. Insert a NOP between → both sels 10.
- ALU-imm ins=01101_00110_00001_00000101_0 → imm_sel=1, imm=0x05. With SIGN_EXT=1, DATA_W=16 and imm field 0x85 → imm=0xFF85.
- Writer to r0, then a reader of r0 → sel 00 when ZERO_REG=1, sel 01 when ZERO_REG=0.
- STORE (op 10101) with rd matching a 1-ahead ALU writer → mux_sel_B=01, mem_en_ex=1, mem_rw_ex=1, wr_en_dm=0 two cycles after issue.
